mips32r1_dmem_responder: RTL and testbench

- Synthesizable data-memory slave for the mips32r1 core's data port.
- Sits directly downstream of the core's DataMem_* pins.
- Services word reads and byte-masked writes with a parameterised, stall-extendable latency, and returns a one-cycle DataMem_Ack.
- Used as the DUT-side memory in the UVM bench, and as the reference model that the data-port monitor checks against.

---
 rtl/mips32r1_mem_pkg.sv | 25 ++
 rtl/mips32r1_bytemask_ram.sv | 28 ++
 rtl/mips32r1_dmem_responder.sv | 140 ++++++++++++++
 tb/tb_mips32r1_dmem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32r1_mem_pkg.sv
// Shared types and constants for the mips32r1 data-memory responder.
package mips32r1_mem_pkg;

    localparam int unsigned ADDR_WORD_W = 30;
    localparam int unsigned DATA_W      = 32;

    localparam int unsigned LANE0 = 0;
    localparam int unsigned LANE1 = 1;
    localparam int unsigned LANE2 = 2;
    localparam int unsigned LANE3 = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    typedef struct packed {
        logic                   read;
        logic [3:0]             strobes;
        logic [ADDR_WORD_W-1:0] addr;
        logic [DATA_W-1:0]      wdata;
    } req_t;

endpackage

// File: rtl/mips32r1_bytemask_ram.sv
// Single-port word RAM with per-byte-lane write enables and a registered read.
module mips32r1_bytemask_ram
    import mips32r1_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we[LANE0]) mem[addr][LANE0*8 +: 8] <= wdata[LANE0*8 +: 8];
        if (we[LANE1]) mem[addr][LANE1*8 +: 8] <= wdata[LANE1*8 +: 8];
        if (we[LANE2]) mem[addr][LANE2*8 +: 8] <= wdata[LANE2*8 +: 8];
        if (we[LANE3]) mem[addr][LANE3*8 +: 8] <= wdata[LANE3*8 +: 8];
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips32r1_dmem_responder.sv
// Data-port memory slave: latched request, stall-extendable latency, one-cycle Ack,
// protocol/range error pulses and completed-transfer counters.
module mips32r1_dmem_responder
    import mips32r1_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   DataMem_Read,
    input  logic [3:0]             DataMem_Write,
    input  logic [ADDR_WORD_W-1:0] DataMem_Address,
    input  logic [DATA_W-1:0]      DataMem_Out,
    output logic [DATA_W-1:0]      DataMem_In,
    output logic                   DataMem_Ack,
    input  logic                   Stall,
    output logic                   ProtoErr,
    output logic                   RangeErr,
    output logic [31:0]            ReadCount,
    output logic [31:0]            WriteCount
);

    localparam logic [ADDR_WORD_W:0] DEPTH_EXT = (ADDR_WORD_W+1)'(DEPTH);
    localparam logic [3:0]           CNT_INIT  = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        proto_q, proto_d;
    logic        range_q, range_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    logic              req_present;
    logic              in_range;
    logic              is_write;
    logic [3:0]        ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign req_present = DataMem_Read | (|DataMem_Write);
    assign in_range    = {1'b0, req_q.addr} < DEPTH_EXT;
    assign is_write    = |req_q.strobes;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        proto_d    = 1'b0;
        range_d    = 1'b0;
        rd_valid_d = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        ram_we     = '0;

        unique case (state_q)
            IDLE: begin
                if (req_present) begin
                    req_d.read    = DataMem_Read;
                    req_d.strobes = DataMem_Write;
                    req_d.addr    = DataMem_Address;
                    req_d.wdata   = DataMem_Out;
                    cnt_d         = CNT_INIT;
                    proto_d       = DataMem_Read & (|DataMem_Write);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // Withdrawal wins over completion so an abort never commits a write.
                if (!req_present) begin
                    proto_d = 1'b1;
                    state_d = IDLE;
                end else if (!Stall) begin
                    if (cnt_q == '0) begin
                        state_d = ACK;
                        range_d = ~in_range;
                        if (in_range) begin
                            ram_we     = req_q.strobes;
                            rd_valid_d = ~is_write;
                        end
                        if (is_write) wr_cnt_d = wr_cnt_q + 32'd1;
                        else          rd_cnt_d = rd_cnt_q + 32'd1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            proto_q    <= 1'b0;
            range_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            proto_q    <= proto_d;
            range_q    <= range_d;
            rd_valid_q <= rd_valid_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    mips32r1_bytemask_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (req_q.addr[ADDR_W-1:0]),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    // RAM output register is not reset, so gate it to keep DataMem_In zero outside a read Ack.
    assign DataMem_In  = rd_valid_q ? ram_rdata : '0;
    assign DataMem_Ack = (state_q == ACK);
    assign ProtoErr    = proto_q;
    assign RangeErr    = range_q;
    assign ReadCount   = rd_cnt_q;
    assign WriteCount  = wr_cnt_q;

endmodule

// File: tb/tb_mips32r1_dmem_responder.sv
// Self-checking bench for mips32r1_dmem_responder against a word-array memory model.
module tb_mips32r1_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic [3:0]  wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    logic        ack;
    logic        stall;
    logic        perr;
    logic        rerr;
    logic [31:0] rcnt;
    logic [31:0] wcnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    int unsigned model_rd = 0;
    int unsigned model_wr = 0;

    mips32r1_dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .DataMem_Read    (rd),
        .DataMem_Write   (wr),
        .DataMem_Address (addr),
        .DataMem_Out     (wdata),
        .DataMem_In      (din),
        .DataMem_Ack     (ack),
        .Stall           (stall),
        .ProtoErr        (perr),
        .RangeErr        (rerr),
        .ReadCount       (rcnt),
        .WriteCount      (wcnt)
    );

    always #5 clk = ~clk;

    // Memory model: expected read data, range flag and protocol flag for one transfer.
    task automatic model_expect(input logic m_rd, input logic [3:0] m_wr, input logic [29:0] m_addr,
                                input logic [31:0] m_wd, output logic [31:0] e_data,
                                output logic e_range, output logic e_pe);
        logic [9:0] idx;
        idx     = m_addr[9:0];
        e_pe    = m_rd && (m_wr != 4'h0);
        e_range = (m_addr >= DEPTH);
        e_data  = 32'h0;
        if (m_wr != 4'h0) begin
            model_wr++;
            if (!e_range)
                for (int b = 0; b < 4; b++)
                    if (m_wr[b]) model_mem[idx][b*8 +: 8] = m_wd[b*8 +: 8];
        end else begin
            model_rd++;
            if (!e_range) e_data = model_mem[idx];
        end
    endtask

    // Drives one request, holds it until Ack (bounded), applies stall_n stalled cycles in WAIT.
    task automatic drive_txn(input logic t_rd, input logic [3:0] t_wr, input logic [29:0] t_addr,
                             input logic [31:0] t_wd, input int stall_n,
                             output int lat, output logic [31:0] rdata, output logic pe,
                             output logic re, output logic ack_one, output logic leak);
        @(negedge clk);
        rd = t_rd; wr = t_wr; addr = t_addr; wdata = t_wd; stall = 1'b0;
        @(posedge clk);
        lat = -1; rdata = '0; pe = 1'b0; re = 1'b0; ack_one = 1'b0; leak = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) pe = perr;
            if (ack) begin
                lat = k - 1;
                rdata = din;
                re = rerr;
                rd = 1'b0; wr = '0; stall = 1'b0;
                @(negedge clk);
                ack_one = !ack;
                break;
            end
            if (din !== '0 || rerr) leak = 1'b1;
            stall = (k <= stall_n);
        end
        rd = 1'b0; wr = '0; stall = 1'b0;
    endtask

    task automatic test_reset();
        rd = 1'b0; wr = '0; addr = '0; wdata = '0; stall = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
        #12;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (din !== 32'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", din); end
        checks++; if ({perr, rerr} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b exp=00", {perr, rerr}); end
        checks++; if (rcnt !== 32'h0 || wcnt !== 32'h0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", rcnt, wcnt); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep;
        model_expect(1'b0, 4'hF, 30'd5, 32'hDEADBEEF, ed, er, ep);
        drive_txn(1'b0, 4'hF, 30'd5, 32'hDEADBEEF, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL wr_ack_data got=%h exp=0", rdata); end
        checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL wr_ack_width got=%b exp=1", a1); end
        model_expect(1'b1, 4'h0, 30'd5, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd5, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rdata); end
        checks++; if (lk !== 1'b0) begin failures++; $display("FAIL rd_leak got=%b exp=0", lk); end
        checks++; if (wcnt !== 32'd1 || rcnt !== 32'd1) begin failures++; $display("FAIL wr_rd_counts got=%0d/%0d exp=1/1", wcnt, rcnt); end
    endtask

    task automatic test_byte_mask();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep;
        model_expect(1'b0, 4'hF, 30'd7, 32'h11223344, ed, er, ep);
        drive_txn(1'b0, 4'hF, 30'd7, 32'h11223344, 0, lat, rdata, pe, re, a1, lk);
        model_expect(1'b0, 4'b0101, 30'd7, 32'hAABBCCDD, ed, er, ep);
        drive_txn(1'b0, 4'b0101, 30'd7, 32'hAABBCCDD, 0, lat, rdata, pe, re, a1, lk);
        model_expect(1'b1, 4'h0, 30'd7, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd7, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (rdata !== 32'h11BB33DD) begin failures++; $display("FAIL byte_mask got=%h exp=11bb33dd", rdata); end
    endtask

    task automatic test_stall();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep;
        model_expect(1'b1, 4'h0, 30'd7, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd7, 32'h0, 3, lat, rdata, pe, re, a1, lk);
        checks++; if (lat !== LAT + 3) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT + 3); end
        checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL stall_ack_width got=%b exp=1", a1); end
        checks++; if (rdata !== ed) begin failures++; $display("FAIL stall_data got=%h exp=%h", rdata, ed); end
    endtask

    task automatic test_proto_err();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep;
        model_expect(1'b1, 4'h3, 30'd10, 32'hCAFEF00D, ed, er, ep);
        drive_txn(1'b1, 4'h3, 30'd10, 32'hCAFEF00D, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (pe !== 1'b1) begin failures++; $display("FAIL proto_pulse got=%b exp=1", pe); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL proto_ack got=%0d exp=%0d", lat, LAT); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL proto_ack_data got=%h exp=0", rdata); end
        model_expect(1'b1, 4'h0, 30'd10, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd10, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (rdata !== 32'h0000F00D) begin failures++; $display("FAIL proto_write_done got=%h exp=0000f00d", rdata); end
        checks++; if (wcnt !== model_wr) begin failures++; $display("FAIL proto_wcount got=%0d exp=%0d", wcnt, model_wr); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep;
        model_expect(1'b1, 4'h0, 30'h3FFFFFF, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'h3FFFFFF, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (re !== 1'b1) begin failures++; $display("FAIL range_rd_flag got=%b exp=1", re); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL range_rd_data got=%h exp=0", rdata); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL range_rd_ack got=%0d exp=%0d", lat, LAT); end
        model_expect(1'b0, 4'hF, 30'd1024, 32'hFFFFFFFF, ed, er, ep);
        drive_txn(1'b0, 4'hF, 30'd1024, 32'hFFFFFFFF, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (re !== 1'b1) begin failures++; $display("FAIL range_wr_flag got=%b exp=1", re); end
        model_expect(1'b1, 4'h0, 30'd0, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd0, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (rdata !== ed) begin failures++; $display("FAIL range_wr_dropped got=%h exp=%h", rdata, ed); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL range_in_bounds_flag got=%b exp=0", re); end
        checks++; if (rcnt !== model_rd || wcnt !== model_wr) begin failures++; $display("FAIL range_counts got=%0d/%0d exp=%0d/%0d", rcnt, wcnt, model_rd, model_wr); end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep; logic saw_ack, pe2;
        @(negedge clk);
        rd = 1'b0; wr = 4'hF; addr = 30'd9; wdata = 32'h5555AAAA;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; wr = 4'h0;
        @(negedge clk);
        pe2 = perr;
        saw_ack = ack;
        repeat (6) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        checks++; if (pe2 !== 1'b1) begin failures++; $display("FAIL abort_proto got=%b exp=1", pe2); end
        checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", saw_ack); end
        checks++; if (rcnt !== model_rd || wcnt !== model_wr) begin failures++; $display("FAIL abort_counts got=%0d/%0d exp=%0d/%0d", rcnt, wcnt, model_rd, model_wr); end
        model_expect(1'b1, 4'h0, 30'd9, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd9, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (rdata !== ed) begin failures++; $display("FAIL abort_mem got=%h exp=%h", rdata, ed); end
    endtask

    task automatic test_mid_write_reset();
        int lat; logic [31:0] rdata, ed; logic pe, re, a1, lk, er, ep; logic saw_ack;
        @(negedge clk);
        rd = 1'b0; wr = 4'hF; addr = 30'd3; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd = 1'b0; wr = 4'h0;
        #1;
        saw_ack = ack;
        checks++; if (rcnt !== 32'h0 || wcnt !== 32'h0) begin failures++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", rcnt, wcnt); end
        repeat (3) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        reset = 1'b1;
        model_rd = 0; model_wr = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL midrst_no_ack got=%b exp=0", saw_ack); end
        model_expect(1'b1, 4'h0, 30'd3, 32'h0, ed, er, ep);
        drive_txn(1'b1, 4'h0, 30'd3, 32'h0, 0, lat, rdata, pe, re, a1, lk);
        checks++; if (rdata !== 32'h0 || rdata !== ed) begin failures++; $display("FAIL midrst_mem got=%h exp=%h", rdata, ed); end
    endtask

    task automatic test_back_to_back();
        int first, second; logic [31:0] d1, d2, e1, e2; logic er, ep;
        model_expect(1'b1, 4'h0, 30'd5, 32'h0, e1, er, ep);
        model_expect(1'b1, 4'h0, 30'd7, 32'h0, e2, er, ep);
        first = -1; second = -1; d1 = '0; d2 = '0;
        @(negedge clk);
        rd = 1'b1; wr = 4'h0; addr = 30'd5;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack) begin
                if (first < 0) begin
                    first = k; d1 = din; addr = 30'd7;
                end else begin
                    second = k; d2 = din; rd = 1'b0;
                    break;
                end
            end
        end
        rd = 1'b0;
        @(negedge clk);
        checks++; if (first !== LAT + 1) begin failures++; $display("FAIL b2b_first got=%0d exp=%0d", first, LAT + 1); end
        checks++; if (second - first !== LAT + 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", second - first, LAT + 2); end
        checks++; if (d1 !== e1 || d2 !== e2) begin failures++; $display("FAIL b2b_data got=%h/%h exp=%h/%h", d1, d2, e1, e2); end
        checks++; if (rcnt !== model_rd) begin failures++; $display("FAIL b2b_rcount got=%0d exp=%0d", rcnt, model_rd); end
    endtask

    task automatic test_random();
        int lat, st; logic [31:0] rdata, ed, wd; logic pe, re, a1, lk, er, ep;
        logic t_rd; logic [3:0] t_wr; logic [29:0] t_addr; int kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            t_rd = (kind != 1);
            t_wr = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            t_addr = ($urandom_range(0, 7) == 0) ? 30'(DEPTH + $urandom_range(0, 5000))
                                                 : 30'($urandom_range(0, 31));
            wd = $urandom;
            st = $urandom_range(0, 3);
            model_expect(t_rd, t_wr, t_addr, wd, ed, er, ep);
            drive_txn(t_rd, t_wr, t_addr, wd, st, lat, rdata, pe, re, a1, lk);
            checks++; if (lat !== LAT + st) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, LAT + st); end
            checks++; if (rdata !== ed) begin failures++; $display("FAIL rand_data n=%0d addr=%0d got=%h exp=%h", n, t_addr, rdata, ed); end
            checks++; if (pe !== ep) begin failures++; $display("FAIL rand_proto n=%0d got=%b exp=%b", n, pe, ep); end
            checks++; if (re !== er) begin failures++; $display("FAIL rand_range n=%0d got=%b exp=%b", n, re, er); end
            checks++; if (a1 !== 1'b1 || lk !== 1'b0) begin failures++; $display("FAIL rand_ack_shape n=%0d got=%b%b exp=10", n, a1, lk); end
        end
        checks++; if (rcnt !== model_rd || wcnt !== model_wr) begin failures++; $display("FAIL rand_counts got=%0d/%0d exp=%0d/%0d", rcnt, wcnt, model_rd, model_wr); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_stall();
        test_proto_err();
        test_range();
        test_abort();
        test_mid_write_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
